// File: rtl/data_mem_if.sv
// Request/response bus between a load/store initiator and data_mem_responder.
interface data_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_be, req_wdata, req_pc, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_be, req_wdata, req_pc, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data memory with fixed access latency and byte-enable writes.
// Optional write trace printout enabled by defining DMRESP_TRACE_EN.
module data_mem_responder #(
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    data_mem_if.slave   bus
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [31:0]     addr_q, addr_d;
    logic [3:0]      be_q, be_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;
    logic            mem_wen_d;
    logic [31:0]     mem_wdata_d;
    logic [31:0]     mem_q [DEPTH_WORDS];

    logic [AW-1:0]   idx_c;
    logic            in_range_c;
    logic [31:0]     rd_word_c;
    logic            unused_c;

`ifdef DMRESP_TRACE_EN
    logic [31:0]     pc_q, pc_d;
    assign unused_c = ^addr_q[1:0];
`else
    assign unused_c = ^{bus.req_pc, addr_q[1:0]};
`endif

    assign idx_c      = addr_q[AW+1:2];
    assign in_range_c = (addr_q >> (AW + 2)) == 32'd0;
    assign rd_word_c  = mem_q[idx_c];

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    // Byte-merge of the latched write data into the currently stored word.
    always_comb begin
        mem_wdata_d = rd_word_c;
        for (int i = 0; i < 4; i++) begin
            if (be_q[i]) mem_wdata_d[8*i +: 8] = wdata_q[8*i +: 8];
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_wen_d   = 1'b0;
`ifdef DMRESP_TRACE_EN
        pc_d        = pc_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    be_d    = bus.req_be;
                    wdata_d = bus.req_wdata;
`ifdef DMRESP_TRACE_EN
                    pc_d    = bus.req_pc;
`endif
                    cnt_d   = CW'(LATENCY);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = ~in_range_c;
                    rsp_rdata_d = in_range_c ? rd_word_c : 32'd0;
                    mem_wen_d   = we_q && in_range_c && (be_q != 4'd0);
                    state_d     = RESP;
                end else begin
                    cnt_d = CW'(cnt_q - CW'(1));
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef DMRESP_TRACE_EN
            pc_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef DMRESP_TRACE_EN
            pc_q        <= pc_d;
`endif
        end
    end

    // Storage array; reset clears every word and wins over a pending commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
        end else if (mem_wen_d) begin
            mem_q[idx_c] <= mem_wdata_d;
`ifdef DMRESP_TRACE_EN
            $display("%d @%h: *%h <= %h", $time, pc_q, {addr_q[31:2], 2'b00}, mem_wdata_d);
`endif
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (LATENCY=2 and LATENCY=0 instances).
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    data_mem_if bus();
    data_mem_if bus0();

    data_mem_responder #(.LATENCY(2), .DEPTH_WORDS(1024)) u_dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    data_mem_responder #(.LATENCY(0), .DEPTH_WORDS(16)) u_dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction on the LATENCY=2 instance; lat = cycles from accept to rsp_valid.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wdata, output logic [31:0] rdata,
                       output logic err, output int lat);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr;
        bus.req_be = be; bus.req_wdata = wdata; bus.req_pc = 32'h0000_1000 + addr;
        tick();
        bus.req_valid = 1'b0;
        lat = 0;
        while (bus.rsp_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h40;
        bus.req_be = 4'hF; bus.req_wdata = 32'h1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.req_valid = 1'b0;
        n_checks++; if (bus.req_ready !== 1'b1) begin n_errors++; $display("FAIL reset_req_ready: got %b exp 1", bus.req_ready); end
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_valid: got %b exp 0", bus.rsp_valid); end
        n_checks++; if (bus.rsp_rdata !== 32'h0) begin n_errors++; $display("FAIL reset_rsp_rdata: got %h exp 00000000", bus.rsp_rdata); end
        n_checks++; if (bus.rsp_err !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_err: got %b exp 0", bus.rsp_err); end
        tick();
        n_checks++; if (bus.req_ready !== 1'b1) begin n_errors++; $display("FAIL reset_priority_idle: got %b exp 1", bus.req_ready); end
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic er; int lat;
        txn(1'b1, 32'h10, 4'hF, 32'h1234_5678, rd, er, lat);
        n_checks++; if (rd !== 32'h0) begin n_errors++; $display("FAIL wr_prev_rdata: got %h exp 00000000", rd); end
        n_checks++; if (er !== 1'b0) begin n_errors++; $display("FAIL wr_err: got %b exp 0", er); end
        n_checks++; if (lat != 3) begin n_errors++; $display("FAIL wr_latency: got %0d exp 3", lat); end
        txn(1'b0, 32'h10, 4'h0, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'h1234_5678) begin n_errors++; $display("FAIL rd_rdata: got %h exp 12345678", rd); end
        n_checks++; if (er !== 1'b0) begin n_errors++; $display("FAIL rd_err: got %b exp 0", er); end
    endtask

    task automatic test_byte_enable();
        logic [31:0] rd; logic er; int lat;
        txn(1'b1, 32'h10, 4'b0010, 32'h0000_AB00, rd, er, lat);
        n_checks++; if (rd !== 32'h1234_5678) begin n_errors++; $display("FAIL be_prev_rdata: got %h exp 12345678", rd); end
        txn(1'b0, 32'h10, 4'h0, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'h1234_AB78) begin n_errors++; $display("FAIL be_merge: got %h exp 1234ab78", rd); end
        txn(1'b1, 32'h10, 4'b0000, 32'hFFFF_FFFF, rd, er, lat);
        txn(1'b0, 32'h13, 4'h0, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'h1234_AB78) begin n_errors++; $display("FAIL be_zero_noop: got %h exp 1234ab78", rd); end
        txn(1'b1, 32'h11, 4'b1001, 32'hEE00_00DD, rd, er, lat);
        txn(1'b0, 32'h10, 4'h0, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'hEE34_ABDD) begin n_errors++; $display("FAIL be_outer_bytes: got %h exp ee34abdd", rd); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h10; bus.req_be = 4'h0;
        tick();
        // Keep a conflicting write presented while not idle; it must be ignored.
        bus.req_we = 1'b1; bus.req_be = 4'hF; bus.req_wdata = 32'h0; bus.req_addr = 32'h10;
        lat = 0;
        while (bus.rsp_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
        n_checks++; if (lat != 3) begin n_errors++; $display("FAIL bp_latency: got %0d exp 3", lat); end
        for (int c = 0; c < 5; c++) begin
            n_checks++; if (bus.rsp_valid !== 1'b1) begin n_errors++; $display("FAIL bp_hold_valid[%0d]: got %b exp 1", c, bus.rsp_valid); end
            n_checks++; if (bus.rsp_rdata !== 32'hEE34_ABDD) begin n_errors++; $display("FAIL bp_hold_rdata[%0d]: got %h exp ee34abdd", c, bus.rsp_rdata); end
            n_checks++; if (bus.req_ready !== 1'b0) begin n_errors++; $display("FAIL bp_hold_ready[%0d]: got %b exp 0", c, bus.req_ready); end
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
        n_checks++; if (bus.req_ready !== 1'b1) begin n_errors++; $display("FAIL bp_release_ready: got %b exp 1", bus.req_ready); end
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_errors++; $display("FAIL bp_release_valid: got %b exp 0", bus.rsp_valid); end
        txn(1'b0, 32'h10, 4'h0, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'hEE34_ABDD) begin n_errors++; $display("FAIL bp_ignored_write: got %h exp ee34abdd", rd); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; logic er; int lat;
        txn(1'b1, 32'h1000, 4'hF, 32'hFFFF_FFFF, rd, er, lat);
        n_checks++; if (er !== 1'b1) begin n_errors++; $display("FAIL oor_wr_err: got %b exp 1", er); end
        n_checks++; if (rd !== 32'h0) begin n_errors++; $display("FAIL oor_wr_rdata: got %h exp 00000000", rd); end
        txn(1'b0, 32'h0, 4'h0, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'h0) begin n_errors++; $display("FAIL oor_no_alias: got %h exp 00000000", rd); end
        n_checks++; if (er !== 1'b0) begin n_errors++; $display("FAIL oor_alias_err: got %b exp 0", er); end
        txn(1'b1, 32'hFFC, 4'hF, 32'hCAFE_F00D, rd, er, lat);
        n_checks++; if (er !== 1'b0) begin n_errors++; $display("FAIL top_word_err: got %b exp 0", er); end
        txn(1'b0, 32'hFFC, 4'h0, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'hCAFE_F00D) begin n_errors++; $display("FAIL top_word_rdata: got %h exp cafef00d", rd); end
        txn(1'b0, 32'hFFFF_FFFC, 4'h0, 32'h0, rd, er, lat);
        n_checks++; if (er !== 1'b1 || rd !== 32'h0) begin n_errors++; $display("FAIL oor_rd_high: got err=%b rdata=%h exp err=1 rdata=00000000", er, rd); end
    endtask

    task automatic test_reset_busy();
        logic [31:0] rd; logic er; int lat;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h20;
        bus.req_be = 4'hF; bus.req_wdata = 32'hDEAD_BEEF;
        tick();
        bus.req_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if (bus.req_ready !== 1'b1) begin n_errors++; $display("FAIL rst_busy_ready: got %b exp 1", bus.req_ready); end
        tick(); tick(); tick();
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_errors++; $display("FAIL rst_busy_no_rsp: got %b exp 0", bus.rsp_valid); end
        txn(1'b0, 32'h20, 4'h0, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'h0) begin n_errors++; $display("FAIL rst_busy_no_write: got %h exp 00000000", rd); end
        // Reset while a response is waiting for rsp_ready.
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h20;
        tick();
        bus.req_valid = 1'b0;
        lat = 0;
        while (bus.rsp_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
        n_checks++; if (lat != 3) begin n_errors++; $display("FAIL rst_resp_latency: got %0d exp 3", lat); end
        bus.rsp_ready = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.rsp_ready = 1'b0;
        n_checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin n_errors++; $display("FAIL rst_resp_drop: got valid=%b ready=%b exp valid=0 ready=1", bus.rsp_valid, bus.req_ready); end
    endtask

    task automatic test_latency0();
        bus0.req_valid = 1'b1; bus0.req_we = 1'b1; bus0.req_addr = 32'h4;
        bus0.req_be = 4'hF; bus0.req_wdata = 32'hA5A5_A5A5;
        tick();
        bus0.req_valid = 1'b0;
        n_checks++; if (bus0.rsp_valid !== 1'b0) begin n_errors++; $display("FAIL lat0_accept_cycle: got %b exp 0", bus0.rsp_valid); end
        tick();
        n_checks++; if (bus0.rsp_valid !== 1'b1 || bus0.rsp_rdata !== 32'h0) begin n_errors++; $display("FAIL lat0_wr_rsp: got valid=%b rdata=%h exp valid=1 rdata=00000000", bus0.rsp_valid, bus0.rsp_rdata); end
        bus0.rsp_ready = 1'b1;
        tick();
        bus0.rsp_ready = 1'b0;
        bus0.req_valid = 1'b1; bus0.req_we = 1'b0; bus0.req_addr = 32'h4;
        tick();
        bus0.req_valid = 1'b0;
        tick();
        n_checks++; if (bus0.rsp_valid !== 1'b1 || bus0.rsp_rdata !== 32'hA5A5_A5A5) begin n_errors++; $display("FAIL lat0_rd_rsp: got valid=%b rdata=%h exp valid=1 rdata=a5a5a5a5", bus0.rsp_valid, bus0.rsp_rdata); end
        bus0.rsp_ready = 1'b1;
        tick();
        bus0.rsp_ready = 1'b0;
        bus0.req_valid = 1'b1; bus0.req_addr = 32'h40;
        tick();
        bus0.req_valid = 1'b0;
        tick();
        n_checks++; if (bus0.rsp_err !== 1'b1 || bus0.rsp_rdata !== 32'h0) begin n_errors++; $display("FAIL lat0_oor: got err=%b rdata=%h exp err=1 rdata=00000000", bus0.rsp_err, bus0.rsp_rdata); end
        bus0.rsp_ready = 1'b1;
        tick();
        bus0.rsp_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_be = '0;
        bus.req_wdata = '0; bus.req_pc = '0; bus.rsp_ready = 1'b0;
        bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0; bus0.req_be = '0;
        bus0.req_wdata = '0; bus0.req_pc = '0; bus0.rsp_ready = 1'b0;
        tick();
        test_reset();
        test_write_read();
        test_byte_enable();
        test_backpressure();
        test_out_of_range();
        test_reset_busy();
        test_latency0();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout exp completion");
        $fatal(1, "watchdog expired");
    end
endmodule
